// File: rtl/ram_arb_ctrl.sv
// Two-requester arbitrated 16-word RAM controller with round-robin tie-break.
// Latency: grant at the sampling edge, array access one edge later, done pulse in the following cycle.
// Backpressure: requests are sampled only in IDLE; a losing or late requester holds req until granted.
module ram_arb_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [3:0]        addr_a,
  input  logic [3:0]        addr_b,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic [DATA_W-1:0] wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              done_a,
  output logic              done_b,
  output logic [DATA_W-1:0] rdata,
  output logic [15:0]       row_sel
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic                rr_ptr;      // 0: A wins a tie, 1: B wins a tie
  logic                cap_we;
  logic [3:0]          cap_addr;
  logic [DATA_W-1:0]   cap_wdata;
  logic [DATA_W-1:0]   mem [16];

  logic                pick_b;
  logic                sel_we;
  logic [3:0]          sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // Winner selection: a lone requester always wins; on a tie the pointer decides.
  always_comb begin
    pick_b    = req_b & (~req_a | rr_ptr);
    sel_we    = pick_b ? we_b    : we_a;
    sel_addr  = pick_b ? addr_b  : addr_a;
    sel_wdata = pick_b ? wdata_b : wdata_a;
  end

  // Controller FSM, storage array and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      cap_we    <= 1'b0;
      cap_addr  <= 4'd0;
      cap_wdata <= '0;
      gnt_a     <= 1'b0;
      gnt_b     <= 1'b0;
      done_a    <= 1'b0;
      done_b    <= 1'b0;
      rdata     <= '0;
      row_sel   <= '0;
      for (int i = 0; i < 16; i++) begin
        mem[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (req_a | req_b) begin
            gnt_a     <= ~pick_b;
            gnt_b     <= pick_b;
            cap_we    <= sel_we;
            cap_addr  <= sel_addr;
            cap_wdata <= sel_wdata;
            // Next tie goes to whoever lost (or did not ask) this time.
            rr_ptr    <= ~pick_b;
            row_sel   <= 16'd1 << sel_addr;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cap_we) begin
            mem[cap_addr] <= cap_wdata;
          end else begin
            rdata <= mem[cap_addr];
          end
          done_a  <= gnt_a;
          done_b  <= gnt_b;
          row_sel <= '0;
          state   <= DONE;
        end
        DONE: begin
          gnt_a  <= 1'b0;
          gnt_b  <= 1'b0;
          done_a <= 1'b0;
          done_b <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          gnt_a   <= 1'b0;
          gnt_b   <= 1'b0;
          done_a  <= 1'b0;
          done_b  <= 1'b0;
          row_sel <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arb_ctrl.sv
// Directed table-driven bench for ram_arb_ctrl plus a round-robin sequence.
// Each vector is one clock: inputs driven on the falling edge, outputs checked 1 time unit after the rising edge.
// Expected values are hand-computed constants and a tiny owner/rdata tracker for the tie sequence.
module tb_ram_arb_ctrl;

  logic       clk;
  logic       rst;
  logic       req_a, req_b, we_a, we_b;
  logic [3:0] addr_a, addr_b;
  logic [7:0] wdata_a, wdata_b;
  logic       gnt_a, gnt_b, done_a, done_b;
  logic [7:0] rdata;
  logic [15:0] row_sel;

  int n_vec;
  int n_bad;

  typedef struct {
    logic       rst;
    logic       ra;
    logic       wa;
    logic [3:0] aa;
    logic [7:0] da;
    logic       rb;
    logic       wb;
    logic [3:0] ab;
    logic [7:0] db;
    logic       ga;
    logic       gb;
    logic       dna;
    logic       dnb;
    logic [15:0] row;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs[$];

  ram_arb_ctrl #(.DATA_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_a   (req_a),
    .req_b   (req_b),
    .we_a    (we_a),
    .we_b    (we_b),
    .addr_a  (addr_a),
    .addr_b  (addr_b),
    .wdata_a (wdata_a),
    .wdata_b (wdata_b),
    .gnt_a   (gnt_a),
    .gnt_b   (gnt_b),
    .done_a  (done_a),
    .done_b  (done_b),
    .rdata   (rdata),
    .row_sel (row_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic r,
                              input logic ra, input logic wa, input logic [3:0] aa, input logic [7:0] da,
                              input logic rb, input logic wb, input logic [3:0] ab, input logic [7:0] db,
                              input logic ga, input logic gb, input logic dna, input logic dnb,
                              input logic [15:0] row, input logic [7:0] rd);
    vec_t v;
    v.rst = r;  v.ra = ra; v.wa = wa; v.aa = aa; v.da = da;
    v.rb = rb;  v.wb = wb; v.ab = ab; v.db = db;
    v.ga = ga;  v.gb = gb; v.dna = dna; v.dnb = dnb; v.row = row; v.rd = rd;
    vecs.push_back(v);
  endfunction

  task automatic drive(input logic r,
                       input logic ra, input logic wa, input logic [3:0] aa, input logic [7:0] da,
                       input logic rb, input logic wb, input logic [3:0] ab, input logic [7:0] db);
    @(negedge clk);
    rst = r;
    req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
    req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [27:0] exp);
    logic [27:0] got;
    got = {gnt_a, gnt_b, done_a, done_b, row_sel, rdata};
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got gnt_a/b=%b%b done_a/b=%b%b row_sel=%h rdata=%h, want gnt_a/b=%b%b done_a/b=%b%b row_sel=%h rdata=%h",
               name, idx, got[27], got[26], got[25], got[24], got[23:8], got[7:0],
               exp[27], exp[26], exp[25], exp[24], exp[23:8], exp[7:0]);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst = 1'b1;
    req_a = 1'b0; we_a = 1'b0; addr_a = 4'd0; wdata_a = 8'h00;
    req_b = 1'b0; we_b = 1'b0; addr_b = 4'd0; wdata_b = 8'h00;

    //   rst ra wa aa     da     rb wb ab     db      ga gb da db row       rd
    // reset state, reset overriding requests, idle with no request
    add(1, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00,  0,0,0,0,16'h0000,8'h00);
    add(1, 1,1,4'h3,8'hA5, 1,1,4'h4,8'h11,  0,0,0,0,16'h0000,8'h00);
    add(0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00,  0,0,0,0,16'h0000,8'h00);
    // single write A: addr 3 <= A5
    add(0, 1,1,4'h3,8'hA5, 0,0,4'h0,8'h00,  1,0,0,0,16'h0008,8'h00);
    add(0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00,  1,0,1,0,16'h0000,8'h00);
    add(0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00,  0,0,0,0,16'h0000,8'h00);
    // read-back by B from addr 3
    add(0, 0,0,4'h0,8'h00, 1,0,4'h3,8'h00,  0,1,0,0,16'h0008,8'h00);
    add(0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00,  0,1,0,1,16'h0000,8'hA5);
    add(0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00,  0,0,0,0,16'h0000,8'hA5);
    // write 3C to addr 15; rdata must not move on a write
    add(0, 1,1,4'hF,8'h3C, 0,0,4'h0,8'h00,  1,0,0,0,16'h8000,8'hA5);
    add(0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00,  1,0,1,0,16'h0000,8'hA5);
    add(0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00,  0,0,0,0,16'h0000,8'hA5);
    // read addr 0 (untouched)
    add(0, 0,0,4'h0,8'h00, 1,0,4'h0,8'h00,  0,1,0,0,16'h0001,8'hA5);
    add(0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00,  0,1,0,1,16'h0000,8'h00);
    add(0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00,  0,0,0,0,16'h0000,8'h00);
    // read addr 15 back
    add(0, 1,0,4'hF,8'h00, 0,0,4'h0,8'h00,  1,0,0,0,16'h8000,8'h00);
    add(0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00,  1,0,1,0,16'h0000,8'h3C);
    add(0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00,  0,0,0,0,16'h0000,8'h3C);
    // write 5A to addr 2, then disturb all inputs during BUSY and DONE
    add(0, 1,1,4'h2,8'h5A, 0,0,4'h0,8'h00,  1,0,0,0,16'h0004,8'h3C);
    add(0, 1,1,4'h9,8'h77, 1,1,4'h9,8'hEE,  1,0,1,0,16'h0000,8'h3C);
    add(0, 1,1,4'h9,8'h77, 1,1,4'h9,8'hEE,  0,0,0,0,16'h0000,8'h3C);
    // addr 2 holds 5A, addr 9 still 00
    add(0, 0,0,4'h0,8'h00, 1,0,4'h2,8'h00,  0,1,0,0,16'h0004,8'h3C);
    add(0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00,  0,1,0,1,16'h0000,8'h5A);
    add(0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00,  0,0,0,0,16'h0000,8'h5A);
    add(0, 0,0,4'h0,8'h00, 1,0,4'h9,8'h00,  0,1,0,0,16'h0200,8'h5A);
    add(0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00,  0,1,0,1,16'h0000,8'h00);
    add(0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00,  0,0,0,0,16'h0000,8'h00);
    // write FF to addr 7 killed by reset in BUSY: no done, memory cleared
    add(0, 1,1,4'h7,8'hFF, 0,0,4'h0,8'h00,  1,0,0,0,16'h0080,8'h00);
    add(1, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00,  0,0,0,0,16'h0000,8'h00);
    add(0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00,  0,0,0,0,16'h0000,8'h00);
    add(0, 1,0,4'h7,8'h00, 0,0,4'h0,8'h00,  1,0,0,0,16'h0080,8'h00);
    add(0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00,  1,0,1,0,16'h0000,8'h00);
    add(0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00,  0,0,0,0,16'h0000,8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].ra, vecs[i].wa, vecs[i].aa, vecs[i].da,
            vecs[i].rb, vecs[i].wb, vecs[i].ab, vecs[i].db);
      check("vec", i, {vecs[i].ga, vecs[i].gb, vecs[i].dna, vecs[i].dnb, vecs[i].row, vecs[i].rd});
    end

    // Round robin: fresh reset, both requesters held high for four transactions.
    // A writes 11 to addr 1, B reads addr 1; order must be A, B, A, B.
    drive(1, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00);
    begin
      logic        own_b;
      logic [7:0]  exp_rd;
      logic [27:0] exp;
      exp_rd = 8'h00;
      for (int t = 0; t < 4; t++) begin
        own_b = (t % 2) == 1;
        for (int c = 0; c < 3; c++) begin
          drive(0, 1,1,4'h1,8'h11, 1,0,4'h1,8'h00);
          if (c == 1 && own_b) exp_rd = 8'h11;
          exp = {(c < 2) && !own_b, (c < 2) && own_b,
                 (c == 1) && !own_b, (c == 1) && own_b,
                 (c == 0) ? 16'h0002 : 16'h0000, exp_rd};
          check("rr", t * 3 + c, exp);
        end
      end
    end
    drive(0, 0,0,4'h0,8'h00, 0,0,4'h0,8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_arb_ctrl.md
RAM_ARB_CTRL -- requirements
Module: ram_arb_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the word width of the 16-word storage array.
REQ-002 The block SHALL have port clk, input, 1, the single clock; every state element SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, a synchronous, active-high reset.
REQ-004 The block SHALL have ports req_a and req_b, input, 1 each, the access requests from requester A and requester B.
REQ-005 The block SHALL have ports we_a and we_b, input, 1 each, where 1 selects write and 0 selects read.
REQ-006 The block SHALL have ports addr_a and addr_b, input, 4 each, the word address.
REQ-007 The block SHALL have ports wdata_a and wdata_b, input, DATA_W each, the write data.
REQ-008 The block SHALL have ports gnt_a and gnt_b, output, 1 each, high while the corresponding requester owns the array.
REQ-009 The block SHALL have ports done_a and done_b, output, 1 each, a one-cycle completion pulse.
REQ-010 The block SHALL have port rdata, output, DATA_W, the read result.
REQ-011 The block SHALL have port row_sel, output, 16, the one-hot decoded word select.

Function
REQ-012 The storage SHALL be 16 words of DATA_W bits, indexed by a 4-bit address.
REQ-013 The controller SHALL be a three-state FSM: IDLE, BUSY and DONE.
REQ-014 In IDLE with no request, the FSM SHALL remain in IDLE.
REQ-015 In IDLE with any req high at a clock edge, the FSM SHALL, at that edge:
- pick a winner;
- set the winner's gnt;
- capture the winner's we, addr and wdata into internal registers;
- move to BUSY.
REQ-016 The winner SHALL be chosen as follows:
- only one req high: that requester wins, regardless of priority;
- both req high: the requester named by the round-robin pointer wins.
REQ-017 After each grant, the pointer SHALL switch to the requester that was not granted.
REQ-018 In BUSY, row_sel SHALL be the one-hot decode of the captured address (bit n high for address n); row_sel SHALL be all zeros in every other state.
REQ-019 In BUSY, at the next clock edge:
- on a write, mem[addr] SHALL take the captured wdata;
- on a read, rdata SHALL take mem[addr];
- the FSM SHALL move to DONE.
REQ-020 In DONE, the granted requester's done SHALL be high for exactly one cycle, and rdata SHALL be valid when the access was a read.
REQ-021 At the edge that leaves DONE, the FSM SHALL return to IDLE and all gnt and done outputs SHALL go low.
REQ-022 A request SHALL be sampled only in IDLE, so one transaction takes 3 cycles and the next grant comes no earlier than the edge after return to IDLE.
REQ-023 A requester whose req is still high in IDLE SHALL be treated as a new request.
REQ-024 Changes on req, we, addr or wdata while the FSM is in BUSY or DONE SHALL have no effect on the transaction in progress.
REQ-025 At most one gnt and at most one done SHALL be high in any cycle.
REQ-026 rdata SHALL hold its value until the next completed read; writes SHALL NOT change rdata.
REQ-027 Writing to and reading from address 15 (4'hF) SHALL behave exactly as for any other address, with no wrap-around or aliasing.

Reset
REQ-028 When rst is high at a clock edge, the block SHALL:
- set the FSM to IDLE;
- clear gnt_a, gnt_b, done_a and done_b to 0;
- clear row_sel and rdata to 0;
- clear all 16 words of storage to 0;
- set the round-robin pointer to A.
REQ-029 Reset SHALL override requests in the same cycle.
REQ-030 Reset asserted while in BUSY SHALL suppress any pending write, and no done pulse SHALL follow.

Verification
REQ-031 A single write SHALL behave as follows: req_a=1, we_a=1, addr_a=3, wdata_a=8'hA5 in IDLE -> gnt_a high for 2 cycles, row_sel=16'h0008 for 1 cycle, done_a pulses in the third cycle, mem[3]=8'hA5.
REQ-032 A read-back SHALL behave as follows: after REQ-031, req_b=1, we_b=0, addr_b=3 -> gnt_b, then done_b with rdata=8'hA5; gnt_a stays 0 throughout.
REQ-033 Round-robin SHALL behave as follows: after reset, req_a and req_b are both held high for 4 transactions -> grant order A, B, A, B, each 3 cycles long, and gnt_a and gnt_b are never high together.
REQ-034 An address boundary SHALL behave as follows: write 8'h3C to address 15, then read address 0 -> row_sel=16'h8000 during the write, rdata=8'h00 after the read (address 0 untouched).
REQ-035 Reset mid-operation SHALL behave as follows: write 8'hFF to address 7 with rst asserted during BUSY -> no done pulse, and a later read of address 7 returns 8'h00.
REQ-036 Input stability SHALL behave as follows: addr_a is changed from 2 to 9 during BUSY -> the access uses address 2, and row_sel=16'h0004.
